// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// Checksum support is compiled in with IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host byte source / memory side.
interface imem_loader_if;
  import imem_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [31:0]       im_addr;
  logic [WORD_W-1:0] im_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; pulses o_word_valid for one cycle
// after every fourth accepted byte.
module byte_assembler
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_word;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clr) begin
        r_cnt  <= '0;
        r_word <= '0;
      end else if (i_accept) begin
        // Newest byte enters at the top so the first byte lands in [7:0].
        r_word  <= {i_byte, r_word[WORD_W-1:BYTE_W]};
        r_cnt   <= r_cnt + 2'd1;
        r_valid <= (r_cnt == 2'd3);
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  loader_state_e     r_state;
  loader_state_e     w_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_len;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_addr;
  logic              w_rx_ready;
  logic              w_accept;
  logic              w_data_acc;
  logic              w_start;
  logic              w_last;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
`endif

  assign w_accept   = bus.rx_valid && w_rx_ready;
  assign w_data_acc = w_accept && (r_state == DATA);
  assign w_start    = start && (r_state inside {IDLE, DONE, ERR});
  assign w_len      = CNT_W'({bus.rx_data, r_len[BYTE_W-1:0]});
  assign w_last     = (CNT_W'(r_idx) + CNT_W'(1)) == r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rx_ready = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LEN0;
      LEN0: begin
        w_rx_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (w_accept) w_next = LEN1;
      end
      LEN1: begin
        w_rx_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (w_accept) begin
          if (w_len == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = CSUM;
`else
            w_next = DONE;
`endif
          else if (w_len > CNT_W'(DEPTH)) w_next = ERR;
          else                            w_next = DATA;
        end
      end
      DATA: begin
        cpu_hold = 1'b1;
        // Ready drops only during the final write so a trailing byte is not
        // swallowed by the assembler.
        w_rx_ready = !(w_word_valid && w_last);
        if (w_word_valid && w_last)
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = CSUM;
`else
          w_next = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        w_rx_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (w_accept) w_next = (bus.rx_data == r_csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) w_next = LEN0;
      end
      ERR: begin
        err = 1'b1;
        if (start) w_next = LEN0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (w_start) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      if (w_accept && r_state == LEN0) r_len[BYTE_W-1:0] <= bus.rx_data;
      if (w_accept && r_state == LEN1) r_len <= w_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_data_acc) r_csum <= r_csum ^ bus.rx_data;
`endif
      if (w_word_valid) begin
        r_idx  <= r_idx + 1'b1;
        r_addr <= r_addr + 32'd4;
      end
    end
  end

  byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_start),
    .i_accept     (w_data_acc),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign bus.rx_ready = w_rx_ready;
  assign bus.im_we    = w_word_valid;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, gaps, length limits, mid-load reset
// and (with IMEM_LOADER_CHECKSUM_EN) checksum accept/reject.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH     (128),
    .BASE_ADDR (32'h0000_0000),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int wr_cnt = 0;
  int base;
  logic [31:0] frm [0:3];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] exp_csum;
`endif

  always @(negedge clk) if (bus.im_we) wr_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; byte is taken at the posedge in between.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int unsigned gaps;
    bit ok;
    gaps = rnd ? $urandom_range(0, 2) : 0;
    ok   = 1'b0;
    if (gaps != 0) begin
      bus.rx_valid = 1'b0;
      repeat (gaps) @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) check_eq("rdy_timeout", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit rnd);
    logic [31:0] w;
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    for (int k = 0; k < n; k++) begin
      w = frm[k];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], rnd);
      check_eq($sformatf("we%0d", k),    32'(bus.im_we), 32'd1);
      check_eq($sformatf("addr%0d", k),  bus.im_addr,    32'(4 * k));
      check_eq($sformatf("wdata%0d", k), bus.im_wdata,   w);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, rnd);
`endif
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20 && !(done || err); i++) @(negedge clk);
    check_eq("end_timeout", 32'(done || err), 32'd1);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    check_eq("rst_ready", 32'(bus.rx_ready), 32'd0);
    check_eq("rst_we",    32'(bus.im_we),    32'd0);
    check_eq("rst_addr",  bus.im_addr,       32'h0);
    check_eq("rst_wdata", bus.im_wdata,      32'h0);
    check_eq("rst_hold",  32'(cpu_hold),     32'd0);
    check_eq("rst_done",  32'(done),         32'd0);
    check_eq("rst_err",   32'(err),          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three words, continuous valid
    frm[0] = 32'h3e80_0093; frm[1] = 32'h7d00_8113; frm[2] = 32'hc181_0193;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_csum = 8'h10;
`endif
    base = wr_cnt;
    pulse_start();
    check_eq("t1_hold",  32'(cpu_hold),     32'd1);
    check_eq("t1_ready", 32'(bus.rx_ready), 32'd1);
    send_frame(3, 1'b0);
    wait_end();
    check_eq("t1_done",  32'(done),         32'd1);
    check_eq("t1_err",   32'(err),          32'd0);
    check_eq("t1_hold2", 32'(cpu_hold),     32'd0);
    check_eq("t1_rdy2",  32'(bus.rx_ready), 32'd0);
    check_eq("t1_nwr",   32'(wr_cnt - base), 32'd3);

    // Same frame with random gaps in rx_valid
    base = wr_cnt;
    pulse_start();
    check_eq("t2_doneclr", 32'(done), 32'd0);
    send_frame(3, 1'b1);
    wait_end();
    check_eq("t2_done", 32'(done),          32'd1);
    check_eq("t2_nwr",  32'(wr_cnt - base), 32'd3);

    // N = 0
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    bus.rx_valid = 1'b0;
    check_eq("t3_done", 32'(done),          32'd1);
    check_eq("t3_err",  32'(err),           32'd0);
    check_eq("t3_hold", 32'(cpu_hold),      32'd0);
    check_eq("t3_nwr",  32'(wr_cnt - base), 32'd0);

    // N = 129 exceeds depth
    base = wr_cnt;
    pulse_start();
    send_byte(8'h81, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("t4_err",   32'(err),          32'd1);
    check_eq("t4_done",  32'(done),         32'd0);
    check_eq("t4_ready", 32'(bus.rx_ready), 32'd0);
    check_eq("t4_hold",  32'(cpu_hold),     32'd0);
    bus.rx_data = 8'h55;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_eq("t4_nwr", 32'(wr_cnt - base), 32'd0);

    // Reset after six data bytes of a two-word frame
    frm[0] = 32'h3e80_0093; frm[1] = 32'h7d00_8113;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h80, 1'b0); send_byte(8'h3e, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h81, 1'b0);
    bus.rx_valid = 1'b0;
    check_eq("t5_addr_pre", bus.im_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_addr",  bus.im_addr,       32'h0);
    check_eq("t5_wdata", bus.im_wdata,      32'h0);
    check_eq("t5_we",    32'(bus.im_we),    32'd0);
    check_eq("t5_hold",  32'(cpu_hold),     32'd0);
    check_eq("t5_ready", 32'(bus.rx_ready), 32'd0);
    check_eq("t5_done",  32'(done),         32'd0);
    check_eq("t5_err",   32'(err),          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_csum = 8'hc2;
`endif
    base = wr_cnt;
    pulse_start();
    send_frame(2, 1'b0);
    wait_end();
    check_eq("t5_done2", 32'(done),          32'd1);
    check_eq("t5_nwr",   32'(wr_cnt - base), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum byte
    frm[0] = 32'h3e80_0093; frm[1] = 32'h7d00_8113; frm[2] = 32'hc181_0193;
    exp_csum = 8'h11;
    pulse_start();
    send_frame(3, 1'b0);
    wait_end();
    check_eq("t6_err",  32'(err),  32'd1);
    check_eq("t6_done", 32'(done), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
